// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared types and helpers for the parametrised serial sequence detector.
//   state_t         : detector FSM states (S_FILL, S_ARMED)
//   DEFAULT_MAX_LEN : default maximum pattern length in bits
//   DEFAULT_CNT_W   : default width of the saturating match counter
//   clamp_len()     : forces a requested pattern length into 1..max_len
package seq_det_pkg;

  localparam int DEFAULT_MAX_LEN = 8;
  localparam int DEFAULT_CNT_W   = 8;

  typedef enum logic {
    S_FILL,
    S_ARMED
  } state_t;

  // A zero-length pattern has no meaning, so it is treated as a single bit;
  // anything longer than the history register is cut down to the full width.
  function automatic int clamp_len(input int len, input int max_len);
    int result;
    if (len < 1) begin
      result = 1;
    end else if (len > max_len) begin
      result = max_len;
    end else begin
      result = len;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_det_history.sv
// seq_det_history
// Shift register holding the most recent accepted bits plus a saturating
// count of how many bits have been collected since the last clear.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   clear      : empties history and fill (wins over shift_en)
//   shift_en   : accept din into the history this cycle
//   din        : serial data bit
//   hist_shift : history as it will look after this cycle's shift (bit 0 = newest)
//   fill_shift : fill as it will look after this cycle's shift
// The "after shift" views let the parent compare against the incoming bit in
// the same cycle; clear is applied only to the stored state, never to these
// views, so the parent may derive clear from them without a loop.
module seq_det_history #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               din,
  output logic [MAX_LEN-1:0] hist_shift,
  output logic [LEN_W-1:0]   fill_shift
);

  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   fill;

  // Next-view of the shift register and fill counter; fill stops at MAX_LEN
  // because once the register is full every later bit keeps it full.
  always_comb begin
    hist_shift = history;
    fill_shift = fill;
    if (shift_en) begin
      hist_shift = {history[MAX_LEN-2:0], din};
      if (fill != LEN_W'(MAX_LEN)) begin
        fill_shift = fill + LEN_W'(1);
      end
    end
  end

  // Stored state: reset and clear both empty the register.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      history <= '0;
      fill    <= '0;
    end else begin
      history <= hist_shift;
      fill    <= fill_shift;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Runtime-configurable serial bit-sequence detector with overlap control,
// input valid qualifier and a saturating match counter.
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset
//   cfg_load    : latch cfg_* this cycle (drops any concurrent data beat)
//   cfg_pattern : pattern, bit [len-1] received first, bit [0] received last
//   cfg_len     : pattern length, clamped into 1..MAX_LEN
//   cfg_overlap : 1 = overlapping matches, 0 = restart after each match
//   din_valid   : din carries a stream bit this cycle
//   din         : serial data bit
//   dout        : registered one-cycle pulse after a completing bit
//   match_count : saturating match count since reset or cfg_load
module seq_detector_param import seq_det_pkg::*; #(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  state_t             state;

  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_shift;
  logic [MAX_LEN-1:0] len_mask;
  logic               accept;
  logic               full_enough;
  logic               match;
  logic               hist_clear;

  // A configuration load owns the cycle, so a data beat alongside it is lost.
  assign accept = din_valid && !cfg_load;

  // Non-overlap mode restarts collection after every hit, which is the same
  // as clearing the history on the matching edge.
  assign hist_clear = cfg_load || (match && !overlap_q);

  seq_det_history #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_history (
    .clk        (clk),
    .reset      (reset),
    .clear      (hist_clear),
    .shift_en   (accept),
    .din        (din),
    .hist_shift (hist_shift),
    .fill_shift (fill_shift)
  );

  // Compare only the low len_q bits of history and pattern; once armed the
  // history stays full, otherwise the freshly counted fill decides.
  always_comb begin
    len_mask    = {MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - len_q);
    full_enough = (state == S_ARMED) || (fill_shift >= len_q);
    match       = accept && full_enough &&
                  ((hist_shift & len_mask) == (pattern_q & len_mask));
  end

  // Configuration, FSM, registered match pulse and saturating counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q   <= '0;
      len_q       <= LEN_W'(MAX_LEN);
      overlap_q   <= 1'b1;
      state       <= S_FILL;
      dout        <= 1'b0;
      match_count <= '0;
    end else if (cfg_load) begin
      pattern_q   <= cfg_pattern;
      len_q       <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
      overlap_q   <= cfg_overlap;
      state       <= S_FILL;
      dout        <= 1'b0;
      match_count <= '0;
    end else if (accept) begin
      dout <= match;
      if (match) begin
        if (match_count != {CNT_W{1'b1}}) begin
          match_count <= match_count + CNT_W'(1);
        end
        state <= overlap_q ? S_ARMED : S_FILL;
      end else begin
        state <= (fill_shift >= len_q) ? S_ARMED : S_FILL;
      end
    end else begin
      dout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param
// Directed and randomized checks of seq_detector_param against a queue-based
// reference model. A second instance with a 2-bit counter exercises saturation.
module tb_seq_detector_param;

  logic       clk;
  logic       reset;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       din_valid;
  logic       din;
  logic       dout;
  logic [7:0] match_count;
  logic       dout_sat;
  logic [1:0] match_count_sat;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: the bits accepted since the last restart, newest last.
  bit         m_bits[$];
  logic [7:0] m_pat;
  int         m_len;
  logic       m_ovl;
  logic       exp_dout;
  logic [7:0] exp_cnt;
  logic [1:0] exp_cnt_sat;

  seq_detector_param #(
    .MAX_LEN (8),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .din_valid   (din_valid),
    .din         (din),
    .dout        (dout),
    .match_count (match_count)
  );

  seq_detector_param #(
    .MAX_LEN (8),
    .CNT_W   (2)
  ) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .din_valid   (din_valid),
    .din         (din),
    .dout        (dout_sat),
    .match_count (match_count_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock edge from the inputs that edge sampled.
  task automatic modelStep(input logic r, input logic ld, input logic v, input logic d);
    bit hit;
    if (r) begin
      m_pat = 8'h00; m_len = 8; m_ovl = 1'b1;
      m_bits.delete();
      exp_dout = 1'b0; exp_cnt = '0; exp_cnt_sat = '0;
    end else if (ld) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : ((cfg_len > 8) ? 8 : int'(cfg_len));
      m_ovl = cfg_overlap;
      m_bits.delete();
      exp_dout = 1'b0; exp_cnt = '0; exp_cnt_sat = '0;
    end else if (v) begin
      m_bits.push_back(d);
      if (m_bits.size() > 8) void'(m_bits.pop_front());
      hit = (m_bits.size() >= m_len);
      for (int k = 0; k < m_len; k++) begin
        if (hit && (m_bits[m_bits.size() - 1 - k] != m_pat[k])) hit = 1'b0;
      end
      exp_dout = hit;
      if (hit) begin
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        if (exp_cnt_sat != 2'b11) exp_cnt_sat = exp_cnt_sat + 2'd1;
        if (!m_ovl) m_bits.delete();
      end
    end else begin
      exp_dout = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag);
    check_count++;
    assert (dout === exp_dout) pass_count++;
    else $error("[TB] FAIL %s dout observed %0b expected %0b", tag, dout, exp_dout);
    check_count++;
    assert (match_count === exp_cnt) pass_count++;
    else $error("[TB] FAIL %s match_count observed %0d expected %0d", tag, match_count, exp_cnt);
    check_count++;
    assert (match_count_sat === exp_cnt_sat) pass_count++;
    else $error("[TB] FAIL %s match_count_sat observed %0d expected %0d", tag, match_count_sat, exp_cnt_sat);
  endtask

  // Drive one cycle, let the edge happen, update the model and compare.
  task automatic applyStimulus(input logic r, input logic ld, input logic v, input logic d,
                               input string tag);
    reset = r; cfg_load = ld; din_valid = v; din = d;
    @(posedge clk);
    modelStep(r, ld, v, d);
    #1;
    checkOutput(tag);
  endtask

  task automatic loadCfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                         input string tag);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, tag);
  endtask

  task automatic sendBits(input logic [7:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, bits[i], tag);
  endtask

  task automatic checkCount(input logic [7:0] want, input string tag);
    check_count++;
    assert (match_count === want) pass_count++;
    else $error("[TB] FAIL %s match_count observed %0d expected %0d", tag, match_count, want);
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; din_valid = 1'b0; din = 1'b0;
    m_pat = '0; m_len = 8; m_ovl = 1'b1;
    exp_dout = 1'b0; exp_cnt = '0; exp_cnt_sat = '0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "reset0");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "reset1");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Overlapping 1011 in 1,0,1,1,0,1,1: hits after bits 4 and 7.
    loadCfg(8'b1011, 4'd4, 1'b1, "load_ovl");
    sendBits(8'b1011011, 7, "ovl_stream");
    checkCount(8'd2, "ovl_total");

    // Same stream without overlap: only the first hit.
    loadCfg(8'b1011, 4'd4, 1'b0, "load_novl");
    sendBits(8'b1011011, 7, "novl_stream");
    checkCount(8'd1, "novl_total");

    // Length-1 pattern: every one is a hit; 2-bit counter saturates at 3.
    loadCfg(8'b1, 4'd1, 1'b1, "load_len1");
    sendBits(8'b11111, 5, "len1_stream");
    checkCount(8'd5, "len1_total");

    // Gap in the valid qualifier: no pulse during the gap, one at the end.
    loadCfg(8'b1011, 4'd4, 1'b1, "load_gap");
    sendBits(8'b10, 2, "gap_head");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "gap_idle");
    sendBits(8'b11, 2, "gap_tail");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "gap_after");

    // Length clamps: 0 behaves as 1, 12 behaves as 8.
    loadCfg(8'b1, 4'd0, 1'b1, "load_len0");
    sendBits(8'b01, 2, "len0_stream");
    loadCfg(8'hA5, 4'd12, 1'b1, "load_len12");
    sendBits(8'hA5, 8, "len12_stream");
    checkCount(8'd1, "len12_total");

    // Load with a concurrent beat drops the beat.
    cfg_pattern = 8'b1; cfg_len = 4'd1; cfg_overlap = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, "load_drop");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "load_drop_next");

    // Reset on the completing bit discards the hit.
    loadCfg(8'b1011, 4'd4, 1'b1, "load_rst");
    sendBits(8'b101, 3, "rst_head");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, "rst_hit");
    sendBits(8'b011, 3, "rst_tail");

    // Randomized traffic with occasional reconfiguration and reset.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_reset");
      end else if ($urandom_range(0, 24) == 0) begin
        cfg_pattern = 8'($urandom);
        cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(1, 4));
        cfg_overlap = 1'($urandom_range(0, 1));
        applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_load");
      end else begin
        applyStimulus(1'b0, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rand_beat");
      end
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised, runtime-configurable serial bit-sequence detector: compares the most recent N accepted bits of a 1-bit stream against a programmable pattern of length 1..MAX_LEN and pulses a registered match flag. It supports overlapping and non-overlapping match modes, a valid qualifier on the input stream, and a saturating match counter. It is the generalised successor to the fixed-pattern serial detectors in the exercise set and sits directly on a serial bit stream, feeding downstream framing/sync logic.

## Interface

- MAX_LEN, 8, maximum pattern length in bits (≥2)
- CNT_W, 8, width of match counter
- LEN_W, $clog2(MAX_LEN+1), derived; width of length fields
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_load  in  1  load new configuration this cycle
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is first bit received, bit [0] is last
- cfg_len  in  LEN_W  pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
- din_valid  in  1  din carries a stream bit this cycle
- din  in  1  serial data bit
- dout  out  1  registered one-cycle match pulse
- match_count  out  CNT_W  saturating count of matches since reset/config load

## Operation

- Registers: pattern_q, len_q, overlap_q, history (MAX_LEN bits, bit 0 = newest), fill (LEN_W, saturates at MAX_LEN), state, dout, match_count.
- Reset: dout=0, match_count=0, history=0, fill=0, pattern_q=0, len_q=MAX_LEN, overlap_q=1, state=S_FILL.
- cfg_load=1: latch cfg_*; cfg_len=0 clamps to 1, cfg_len>MAX_LEN clamps to MAX_LEN; clear history, fill, match_count; state=S_FILL; dout=0 next cycle. cfg_load takes priority: a din_valid beat in the same cycle is dropped.
- din_valid=1 (no cfg_load): history <= {history[MAX_LEN-2:0], din}; fill <= min(fill+1, MAX_LEN).
- States: S_FILL while fill (after update) < len_q; S_ARMED otherwise. S_FILL never matches.
- Match condition on an accepted beat: updated fill ≥ len_q and updated history[len_q-1:0] == pattern_q[len_q-1:0] (upper bits masked).
- On match: dout <= 1; match_count <= match_count+1, holding at 2^CNT_W-1. Overlap mode: history/fill kept, state stays S_ARMED. Non-overlap mode: fill <= 0, state <= S_FILL (history contents irrelevant until refilled).
- No accepted beat (din_valid=0): history, fill, state hold; dout <= 0.
- dout is 0 in every cycle not following a matching beat; it never stays high on a gap.

## Timing

- Latency: dout high exactly in the cycle after the clock edge that accepted the completing bit (one registered stage); match_count updates on the same edge.
- Back-to-back matches (overlap, e.g. len 1 or periodic pattern) produce dout high on consecutive cycles.
- Configuration is effective for the beat in the cycle after cfg_load.
- Reset asserted mid-stream: all state cleared on that edge; a pending match is discarded; dout=0 the following cycle.
- Saturated counter stays at max until reset or cfg_load.

## Structure

- Package seq_det_pkg: state enum {S_FILL, S_ARMED}, length clamp function, default constants for MAX_LEN/CNT_W.
- One sub-module natural: seq_det_history (shift register + saturating fill counter with clear input); comparator, FSM, counter in top.

## Test plan

- MAX_LEN=8, pattern 4'b1011 len 4 overlap=1, stream 1,0,1,1,0,1,1 all valid -> dout pulses after bits 4 and 7; match_count=2.
- Same with overlap=0 -> single pulse after bit 4; match_count=1.
- Pattern len 1 = 1'b1, overlap, stream 1,1,1 -> dout high three consecutive cycles; count=3. With CNT_W=2 and 5 ones -> count holds at 3.
- Pattern 1011, stream 1,0,(din_valid=0 for 3 cycles),1,1 -> single pulse one cycle after last valid beat; no dout during gap.
- cfg_load with cfg_len=0 and then 12 -> len_q=1 and 8 respectively; cfg_load concurrent with din_valid -> beat dropped, fill=0, count cleared.
- Reset asserted the cycle a completing bit arrives -> dout=0 next cycle, match_count=0, subsequent 3 bits of pattern alone produce no match.
